// File: rtl/mac_ci_pkg.sv
// Shared opcodes, FSM encoding and saturation limits for the MAC custom instruction.
// Latency: n/a (definitions only). Backpressure: n/a.
package mac_ci_pkg;

    localparam int ACC_W = 64;

    localparam logic [2:0] OP_CLR    = 3'd0;
    localparam logic [2:0] OP_MAC    = 3'd1;
    localparam logic [2:0] OP_RDLO   = 3'd2;
    localparam logic [2:0] OP_RDHI   = 3'd3;
    localparam logic [2:0] OP_RDSTAT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_ACC,
        ST_RESP
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/mac_ci_mul_pipe.sv
// Signed 32x32->64 multiplier with LAT register stages; product valid LAT enabled cycles after in_vld.
// Backpressure: none; clk_en low freezes every stage.
module mul_pipe
    import mac_ci_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             in_vld,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             out_vld,
    output logic [ACC_W-1:0] out_dat
);

    logic [ACC_W-1:0] dat_q [LAT];
    logic [ACC_W-1:0] dat_d [LAT];
    logic [LAT-1:0]   vld_q;
    logic [LAT-1:0]   vld_d;
    logic signed [ACC_W-1:0] a_ext;
    logic signed [ACC_W-1:0] b_ext;

    always_comb begin
        // Sign-extending both operands first keeps -2^31 * -2^31 = +2^62 exact.
        a_ext = {{(ACC_W-32){a[31]}}, a};
        b_ext = {{(ACC_W-32){b[31]}}, b};
        dat_d[0] = in_vld ? ACC_W'(a_ext * b_ext) : dat_q[0];
        vld_d[0] = in_vld;
        for (int i = 1; i < LAT; i++) begin
            dat_d[i] = dat_q[i-1];
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dat_q <= '{default: '0};
            vld_q <= '0;
        end else if (clk_en) begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_dat = dat_q[LAT-1];

endmodule

// File: rtl/mac_ci.sv
// Nios II multi-cycle MAC custom instruction with 64-bit sticky-saturating accumulator.
// Latency: MAC MUL_LAT+2, other ops 1; start while busy is dropped, clk_en low freezes all state.
module mac_ci
    import mac_ci_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [2:0]  n,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] prod_q, prod_d;
    logic             sat_q, sat_d;
    logic [31:0]      result_q, result_d;
    logic             done_q, done_d;

    logic             pipe_in_vld;
    logic             pipe_vld;
    logic [ACC_W-1:0] pipe_dat;
    logic [ACC_W-1:0] sum;
    logic             ovf;
    logic [ACC_W-1:0] acc_next;

    assign pipe_in_vld = (state_q == ST_IDLE) && start && (n == OP_MAC);

    mul_pipe #(.LAT(MUL_LAT)) u_mul_pipe (
        .clk     (clk),
        .reset   (reset),
        .clk_en  (clk_en),
        .in_vld  (pipe_in_vld),
        .a       (dataa),
        .b       (datab),
        .out_vld (pipe_vld),
        .out_dat (pipe_dat)
    );

    always_comb begin
        sum      = acc_q + prod_q;
        // Overflow only possible when both addends share a sign and the sum flips it.
        ovf      = (acc_q[ACC_W-1] == prod_q[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
        acc_next = ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        sat_d    = sat_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (n == OP_MAC) begin
                        state_d = ST_MUL;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        case (n)
                            OP_CLR: begin
                                acc_d    = '0;
                                sat_d    = 1'b0;
                                result_d = '0;
                            end
                            OP_RDLO:   result_d = acc_q[31:0];
                            OP_RDHI:   result_d = acc_q[ACC_W-1:32];
                            OP_RDSTAT: result_d = {31'b0, sat_q};
                            default:   result_d = '0;
                        endcase
                    end
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q + 3'd1;
                if ((cnt_q == 3'(MUL_LAT - 1)) && pipe_vld) begin
                    prod_d  = pipe_dat;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_d    = acc_next;
                sat_d    = sat_q | ovf;
                result_d = acc_next[31:0];
                done_d   = 1'b1;
                state_d  = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            sat_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            sat_q    <= sat_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mac_ci.sv
// Bench for mac_ci: operation-level reference model checked every cycle, plus directed literal checks.
module tb_mac_ci;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [2:0]  n;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    mac_ci #(.MUL_LAT(MUL_LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Reference model: tracks what software would see, one operation at a time.
    localparam logic signed [64:0] LIM_HI = (65'sd1 <<< 63) - 65'sd1;
    localparam logic signed [64:0] LIM_LO = -(65'sd1 <<< 63);

    logic signed [63:0] m_acc;
    bit                 m_sat;
    logic [31:0]        m_res;
    bit                 m_done;
    bit                 m_busy;
    int                 m_cd;
    longint             m_prod;
    logic signed [64:0] m_wide;
    bit                 m_free;

    always @(posedge clk) begin
        if (reset) begin
            m_acc  = '0;
            m_sat  = 1'b0;
            m_res  = '0;
            m_done = 1'b0;
            m_busy = 1'b0;
            m_cd   = 0;
        end else if (clk_en) begin
            m_free = !m_busy && !m_done;
            m_done = 1'b0;
            if (m_busy) begin
                m_cd = m_cd - 1;
                if (m_cd == 0) begin
                    m_wide = m_acc + m_prod;
                    if (m_wide > LIM_HI) begin
                        m_acc = 64'h7FFF_FFFF_FFFF_FFFF;
                        m_sat = 1'b1;
                    end else if (m_wide < LIM_LO) begin
                        m_acc = 64'h8000_0000_0000_0000;
                        m_sat = 1'b1;
                    end else begin
                        m_acc = m_wide[63:0];
                    end
                    m_res  = m_acc[31:0];
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (m_free && start) begin
                case (n)
                    3'd0: begin m_acc = '0; m_sat = 1'b0; m_res = '0; end
                    3'd1: begin
                        m_prod = longint'($signed(dataa)) * longint'($signed(datab));
                        m_busy = 1'b1;
                        m_cd   = MUL_LAT + 1;
                    end
                    3'd2: m_res = m_acc[31:0];
                    3'd3: m_res = m_acc[63:32];
                    3'd4: m_res = {31'b0, m_sat};
                    default: m_res = '0;
                endcase
                if (n != 3'd1) m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (done !== m_done) begin
                bad++;
                $display("FAIL cyc_done t=%0t got=%0b want=%0b", $time, done, m_done);
            end
            total++;
            if (result !== m_res) begin
                bad++;
                $display("FAIL cyc_result t=%0t got=%h want=%h", $time, result, m_res);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bit seen;
        @(negedge clk);
        n = op; dataa = a; datab = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        lat = 1;
        while (lat <= 20) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, seen ? lat : -1, exp_lat);
        check({name, "_res"}, result, exp_res);
    endtask

    localparam int L_MAC = MUL_LAT + 2;

    initial begin
        int  lat;
        bit  seen;
        reset = 1'b1; clk_en = 1'b1; start = 1'b0;
        n = 3'd0; dataa = '0; datab = '0;
        repeat (3) @(negedge clk);
        check("rst_result", result, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        chk_on = 1'b1;
        reset = 1'b0;

        do_op("rdlo0",   3'd2, 0, 0, 32'h0, 1);
        do_op("rdhi0",   3'd3, 0, 0, 32'h0, 1);
        do_op("rdstat0", 3'd4, 0, 0, 32'h0, 1);

        do_op("clr1",    3'd0, 0, 0, 32'h0, 1);
        do_op("mac3x4",  3'd1, 32'd3, 32'd4, 32'd12, L_MAC);
        do_op("macm2x5", 3'd1, 32'hFFFF_FFFE, 32'd5, 32'd2, L_MAC);
        do_op("rdhi1",   3'd3, 0, 0, 32'h0, 1);

        do_op("clr2",    3'd0, 0, 0, 32'h0, 1);
        do_op("macmin",  3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, L_MAC);
        do_op("rdhi2",   3'd3, 0, 0, 32'hC000_0000, 1);
        do_op("rdlo2",   3'd2, 0, 0, 32'h8000_0000, 1);

        do_op("clr3",    3'd0, 0, 0, 32'h0, 1);
        do_op("macmm",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h0, L_MAC);
        do_op("rdhi3",   3'd3, 0, 0, 32'h4000_0000, 1);
        do_op("rdstat3", 3'd4, 0, 0, 32'h0, 1);

        do_op("clr4",    3'd0, 0, 0, 32'h0, 1);
        do_op("macpp1",  3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h1, L_MAC);
        do_op("macpp2",  3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h2, L_MAC);
        do_op("rdhi4",   3'd3, 0, 0, 32'h7FFF_FFFE, 1);
        do_op("rdstat4", 3'd4, 0, 0, 32'h0, 1);
        do_op("macpp3",  3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, L_MAC);
        do_op("rdhi5",   3'd3, 0, 0, 32'h7FFF_FFFF, 1);
        do_op("rdlo5",   3'd2, 0, 0, 32'hFFFF_FFFF, 1);
        do_op("rdstat5", 3'd4, 0, 0, 32'h1, 1);
        do_op("macm1",   3'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, L_MAC);
        do_op("sticky",  3'd4, 0, 0, 32'h1, 1);
        do_op("clr5",    3'd0, 0, 0, 32'h0, 1);
        do_op("rdstat6", 3'd4, 0, 0, 32'h0, 1);

        do_op("negs1",   3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, L_MAC);
        do_op("negs2",   3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, L_MAC);
        do_op("negs3",   3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, L_MAC);
        do_op("rdhi7",   3'd3, 0, 0, 32'h8000_0000, 1);
        do_op("rdstat7", 3'd4, 0, 0, 32'h1, 1);
        do_op("nop",     3'd5, 0, 0, 32'h0, 1);
        do_op("rdhi8",   3'd3, 0, 0, 32'h8000_0000, 1);

        // MAC(7,6) stalled 3 cycles in MUL, with a second start that must be dropped.
        do_op("clr9", 3'd0, 0, 0, 32'h0, 1);
        @(negedge clk);
        n = 3'd1; dataa = 32'd7; datab = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0; clk_en = 1'b0;
        repeat (3) @(negedge clk);
        clk_en = 1'b1; start = 1'b1; dataa = 32'd1; datab = 32'd1;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("stall_lat", done ? lat : -1, L_MAC + 3);
        check("stall_res", result, 32'd42);
        do_op("stall_rdlo", 3'd2, 0, 0, 32'd42, 1);

        // done must stay high across frozen cycles.
        @(negedge clk);
        n = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; clk_en = 1'b0;
        check("hold_done0", {31'b0, done}, 32'h1);
        repeat (2) @(negedge clk);
        check("hold_done2", {31'b0, done}, 32'h1);
        clk_en = 1'b1;
        @(negedge clk);
        check("hold_fall", {31'b0, done}, 32'h0);
        check("hold_res", result, 32'h0);

        // Reset in MUL discards the pending MAC.
        @(negedge clk);
        n = 3'd1; dataa = 32'd9; datab = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("rst_nodone", {31'b0, seen}, 32'h0);
        do_op("rst_rdlo", 3'd2, 0, 0, 32'h0, 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
